sa_tile_sequencer: RTL and testbench



---
 rtl/sa_tile_sequencer_pkg.sv | 8 +
 rtl/sa_tile_sequencer.sv | 102 ++++++++++
 tb/tb_sa_tile_sequencer.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sa_tile_sequencer_pkg.sv
// sa_pkg: shared state encoding and default widths for the tile sequencer
package sa_pkg;
  localparam int SA_ROWS = 8;
  localparam int SA_INWIDTH = 8;
  localparam int SA_ADDRW = 16;
  localparam int SA_KW = 9;
  typedef enum logic [2:0] {IDLE, ISSUE, FLUSH, DRAIN, DONE} state_t;
endpackage

// File: rtl/sa_tile_sequencer.sv
// sa_tile_sequencer: issues K operand reads per tile, forwards vectors to the core, drains ROWS result beats
module sa_tile_sequencer
  import sa_pkg::*;
#(
  parameter int ROWS = SA_ROWS,
  parameter int INWIDTH = SA_INWIDTH,
  parameter int ADDRW = SA_ADDRW,
  parameter int KW = SA_KW
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [KW-1:0]           cmd_k,
  input  logic [ADDRW-1:0]        cmd_abase,
  input  logic [ADDRW-1:0]        cmd_wbase,
  output logic                    mem_rd_en,
  output logic [ADDRW-1:0]        mem_a_addr,
  output logic [ADDRW-1:0]        mem_w_addr,
  input  logic [ROWS*INWIDTH-1:0] mem_a_data,
  input  logic [ROWS*INWIDTH-1:0] mem_w_data,
  output logic                    core_inpvalid,
  output logic [INWIDTH-1:0]      core_a [ROWS],
  output logic [INWIDTH-1:0]      core_w [ROWS],
  input  logic [ROWS-1:0]         core_rvalid,
  output logic                    core_outread,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic                    busy,
  output logic                    done,
  output logic                    err
);
  localparam int BW = $clog2(ROWS) + 1;
  state_t state;
  logic [KW-1:0] k;
  logic [KW-1:0] n;
  logic [BW-1:0] beat;
  assign cmd_ready = state == IDLE;
  assign busy = state != IDLE;
  assign res_valid = (state == DRAIN) && (&core_rvalid);
  assign core_outread = res_valid && res_ready;
  for (genvar g = 0; g < ROWS; g++) begin : g_lane
    assign core_a[g] = mem_a_data[g*INWIDTH +: INWIDTH];
    assign core_w[g] = mem_w_data[g*INWIDTH +: INWIDTH];
  end
  // Addresses are registered and stepped per read; ADDRW-bit adds wrap naturally
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= IDLE;
      k <= '0;
      n <= '0;
      beat <= '0;
      mem_a_addr <= '0;
      mem_w_addr <= '0;
      mem_rd_en <= 1'b0;
      core_inpvalid <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
    end else begin
      core_inpvalid <= mem_rd_en;
      done <= 1'b0;
      err <= 1'b0;
      case (state)
        IDLE: if (cmd_valid) begin
          if (cmd_k != '0) begin
            k <= cmd_k;
            n <= '0;
            mem_a_addr <= cmd_abase;
            mem_w_addr <= cmd_wbase;
            mem_rd_en <= 1'b1;
            state <= ISSUE;
          end else begin
            done <= 1'b1;
            err <= 1'b1;
            state <= DONE;
          end
        end
        ISSUE: if (n == k - KW'(1)) begin
          mem_rd_en <= 1'b0;
          state <= FLUSH;
        end else begin
          n <= n + KW'(1);
          mem_a_addr <= mem_a_addr + ADDRW'(1);
          mem_w_addr <= mem_w_addr + ADDRW'(1);
        end
        FLUSH: begin
          beat <= '0;
          state <= DRAIN;
        end
        DRAIN: if (core_outread) begin
          beat <= beat + BW'(1);
          if (beat == BW'(ROWS - 1)) begin
            done <= 1'b1;
            state <= DONE;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sa_tile_sequencer.sv
// tb_sa_tile_sequencer: randomized scenarios checked against a cycle-timeline model of the tile protocol
module tb_sa_tile_sequencer;
  localparam int ROWS = 8;
  localparam int INWIDTH = 8;
  localparam int ADDRW = 16;
  localparam int KW = 9;
  localparam int MAXC = 400;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic cmd_valid = 1'b0;
  logic cmd_ready;
  logic [KW-1:0] cmd_k = '0;
  logic [ADDRW-1:0] cmd_abase = '0;
  logic [ADDRW-1:0] cmd_wbase = '0;
  logic mem_rd_en;
  logic [ADDRW-1:0] mem_a_addr, mem_w_addr;
  logic [ROWS*INWIDTH-1:0] mem_a_data, mem_w_data;
  logic core_inpvalid;
  logic [INWIDTH-1:0] core_a [ROWS];
  logic [INWIDTH-1:0] core_w [ROWS];
  logic [ROWS-1:0] core_rvalid = '1;
  logic core_outread, res_valid;
  logic res_ready = 1'b1;
  logic busy, done, err;

  int tests = 0;
  int fails = 0;
  int mseed = 0;
  int rd_cyc[$], iv_cyc[$], or_cyc[$];
  logic [ADDRW-1:0] rd_a[$], rd_w[$];
  logic [ROWS*INWIDTH-1:0] iv_a[$], iv_w[$];
  int done_cyc, err_cyc, viol_nr, viol_part;
  logic rdy0, post_ready, post_rd, post_busy;
  bit rdy_h[512];
  bit full_h[512];

  sa_tile_sequencer dut (
    .clk(clk), .rstn(rstn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_k(cmd_k),
    .cmd_abase(cmd_abase), .cmd_wbase(cmd_wbase), .mem_rd_en(mem_rd_en), .mem_a_addr(mem_a_addr),
    .mem_w_addr(mem_w_addr), .mem_a_data(mem_a_data), .mem_w_data(mem_w_data),
    .core_inpvalid(core_inpvalid), .core_a(core_a), .core_w(core_w), .core_rvalid(core_rvalid),
    .core_outread(core_outread), .res_valid(res_valid), .res_ready(res_ready), .busy(busy),
    .done(done), .err(err)
  );

  always #5 clk = ~clk;

  function automatic logic [ROWS*INWIDTH-1:0] fa(input logic [ADDRW-1:0] ad, input int s);
    logic [ROWS*INWIDTH-1:0] r;
    for (int l = 0; l < ROWS; l++) r[l*INWIDTH +: INWIDTH] = 8'(int'(ad) * 3 + l * 29 + s);
    return r;
  endfunction

  function automatic logic [ROWS*INWIDTH-1:0] fw(input logic [ADDRW-1:0] ad, input int s);
    logic [ROWS*INWIDTH-1:0] r;
    for (int l = 0; l < ROWS; l++) r[l*INWIDTH +: INWIDTH] = 8'(int'(ad) * 5 + l * 17 + s * 3 + 1);
    return r;
  endfunction

  // Operand memories: one-cycle read latency, garbage when not reading
  always @(posedge clk) begin
    mem_a_data <= mem_rd_en ? fa(mem_a_addr, mseed) : {$urandom, $urandom};
    mem_w_data <= mem_rd_en ? fw(mem_w_addr, mseed) : {$urandom, $urandom};
  end

  // Done cycle from the protocol rules: drain opens at K+2, a beat goes on ready && all-valid
  function automatic int exp_done(input int k);
    int c, beats;
    if (k == 0) return 1;
    c = k + 2;
    beats = 0;
    while (beats < ROWS && c < MAXC) begin
      if (rdy_h[c] && full_h[c]) beats++;
      c++;
    end
    return c;
  endfunction

  // Mismatches of the observed read/forward timeline against reads n=0..K-1 at cycle n+1, forwards at n+2
  function automatic int read_errs(input int k, input logic [ADDRW-1:0] ab, input logic [ADDRW-1:0] wb);
    int e;
    logic [ADDRW-1:0] ea, ew;
    e = (rd_cyc.size() != k) + (iv_cyc.size() != k);
    for (int n = 0; n < k; n++) begin
      ea = ADDRW'(int'(ab) + n);
      ew = ADDRW'(int'(wb) + n);
      if (n < rd_cyc.size() && (rd_cyc[n] != n + 1 || rd_a[n] !== ea || rd_w[n] !== ew)) e++;
      if (n < iv_cyc.size() && (iv_cyc[n] != n + 2 || iv_a[n] !== fa(ea, mseed) || iv_w[n] !== fw(ew, mseed))) e++;
    end
    return e;
  endfunction

  task automatic run_tile(input int k, input logic [ADDRW-1:0] ab, input logic [ADDRW-1:0] wb,
                          input int bad, input int rmode, input int rst_at);
    logic [7:0] rv;
    logic [ROWS*INWIDTH-1:0] pa, pw;
    rd_cyc.delete(); rd_a.delete(); rd_w.delete();
    iv_cyc.delete(); iv_a.delete(); iv_w.delete(); or_cyc.delete();
    done_cyc = -1; err_cyc = -1; viol_nr = 0; viol_part = 0;
    mseed = $urandom_range(0, 255);
    for (int i = 0; i < MAXC; i++) begin
      @(negedge clk);
      cmd_valid = (i == 0) || (rmode == 2 && $urandom_range(0, 1) == 1);
      cmd_k = (i == 0) ? KW'(k) : KW'($urandom);
      cmd_abase = (i == 0) ? ab : ADDRW'($urandom);
      cmd_wbase = (i == 0) ? wb : ADDRW'($urandom);
      rstn = (i != rst_at);
      rv = (i >= k + 2 && i < k + 2 + bad) ? 8'hF7 : 8'hFF;
      core_rvalid = rv;
      res_ready = (rmode == 0) ? 1'b1 : (rmode == 1) ? (i % 2 == 0) : 1'($urandom_range(0, 1));
      rdy_h[i] = res_ready;
      full_h[i] = (rv == 8'hFF);
      #1;
      if (i == 0) rdy0 = cmd_ready;
      if (mem_rd_en) begin
        rd_cyc.push_back(i); rd_a.push_back(mem_a_addr); rd_w.push_back(mem_w_addr);
      end
      if (core_inpvalid) begin
        for (int l = 0; l < ROWS; l++) begin
          pa[l*INWIDTH +: INWIDTH] = core_a[l];
          pw[l*INWIDTH +: INWIDTH] = core_w[l];
        end
        iv_cyc.push_back(i); iv_a.push_back(pa); iv_w.push_back(pw);
      end
      if (core_outread) or_cyc.push_back(i);
      if (core_outread && !res_ready) viol_nr++;
      if (res_valid && rv != 8'hFF) viol_part++;
      if (done && done_cyc < 0) done_cyc = i;
      if (err && err_cyc < 0) err_cyc = i;
      if (rst_at >= 0 && i == rst_at + 1) begin
        post_ready = cmd_ready; post_rd = mem_rd_en; post_busy = busy;
        break;
      end
      if (done) break;
    end
    cmd_valid = 1'b0;
    rstn = 1'b1;
  endtask

  task automatic test_reset;
    rstn = 1'b0; core_rvalid = '1; res_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    tests++;
    if ({cmd_ready, busy, mem_rd_en, core_inpvalid, done, err, res_valid, core_outread} !== 8'b1000_0000) begin
      fails++;
      $display("FAIL reset_ctrl: got %b exp 10000000",
               {cmd_ready, busy, mem_rd_en, core_inpvalid, done, err, res_valid, core_outread});
    end
    tests++;
    if ({mem_a_addr, mem_w_addr} !== 32'h0) begin
      fails++; $display("FAIL reset_addr: got %h exp 0", {mem_a_addr, mem_w_addr});
    end
  endtask

  task automatic test_issue;
    run_tile(4, 16'h0010, 16'h0100, 0, 0, -1);
    tests++;
    if (rd_cyc.size() != 4 || rd_a[0] !== 16'h0010 || rd_a[3] !== 16'h0013 || rd_w[3] !== 16'h0103) begin
      fails++; $display("FAIL issue_addr: got %0d reads last A=%h W=%h exp 4 reads A=0013 W=0103",
                        rd_cyc.size(), rd_a[$], rd_w[$]);
    end
    tests++;
    if (read_errs(4, 16'h0010, 16'h0100) !== 0) begin
      fails++; $display("FAIL issue_fwd: got %0d timeline errors exp 0", read_errs(4, 16'h0010, 16'h0100));
    end
    tests++;
    if (done_cyc !== 4 + 2 + ROWS) begin
      fails++; $display("FAIL issue_done: got %0d exp %0d", done_cyc, 4 + 2 + ROWS);
    end
  endtask

  task automatic test_drain_k3;
    run_tile(3, 16'h1234, 16'h4321, 0, 0, -1);
    tests++;
    if (or_cyc.size() != ROWS || or_cyc[0] != 5 || or_cyc[$] != 12) begin
      fails++; $display("FAIL drain_beats: got %0d beats first %0d last %0d exp 8 beats 5..12",
                        or_cyc.size(), or_cyc[0], or_cyc[$]);
    end
    tests++;
    if (done_cyc !== 13 || err_cyc !== -1) begin
      fails++; $display("FAIL drain_done: got done %0d err %0d exp done 13 err -1", done_cyc, err_cyc);
    end
  endtask

  task automatic test_partial;
    run_tile(2, 16'h0200, 16'h0300, 2, 1, -1);
    tests++;
    if (viol_part !== 0 || viol_nr !== 0) begin
      fails++; $display("FAIL partial_viol: got partial %0d noready %0d exp 0 0", viol_part, viol_nr);
    end
    tests++;
    if (or_cyc.size() != ROWS || done_cyc !== exp_done(2)) begin
      fails++; $display("FAIL partial_done: got %0d beats done %0d exp 8 beats done %0d",
                        or_cyc.size(), done_cyc, exp_done(2));
    end
  endtask

  task automatic test_kzero;
    run_tile(0, 16'h0050, 16'h0060, 0, 0, -1);
    tests++;
    if (done_cyc !== 1 || err_cyc !== 1 || rd_cyc.size() != 0) begin
      fails++; $display("FAIL kzero: got done %0d err %0d reads %0d exp 1 1 0", done_cyc, err_cyc, rd_cyc.size());
    end
    run_tile(1, 16'h0070, 16'h0080, 0, 0, -1);
    tests++;
    if (rdy0 !== 1'b1 || err_cyc !== -1 || done_cyc !== exp_done(1)) begin
      fails++; $display("FAIL kzero_next: got ready %b err %0d done %0d exp 1 -1 %0d", rdy0, err_cyc, done_cyc, exp_done(1));
    end
  endtask

  task automatic test_wrap;
    run_tile(4, 16'hFFFE, 16'hFFFF, 0, 0, -1);
    tests++;
    if (rd_cyc.size() != 4 || rd_a[2] !== 16'h0000 || rd_a[3] !== 16'h0001 || rd_w[1] !== 16'h0000) begin
      fails++; $display("FAIL wrap_addr: got %0d reads A2=%h A3=%h W1=%h exp 4 0000 0001 0000",
                        rd_cyc.size(), rd_a[2], rd_a[3], rd_w[1]);
    end
    tests++;
    if (read_errs(4, 16'hFFFE, 16'hFFFF) !== 0 || err_cyc !== -1) begin
      fails++; $display("FAIL wrap_fwd: got %0d errors err %0d exp 0 -1", read_errs(4, 16'hFFFE, 16'hFFFF), err_cyc);
    end
  endtask

  task automatic test_reset_mid;
    run_tile(100, 16'h0400, 16'h0800, 0, 0, 38);
    tests++;
    if (rd_cyc.size() != 38 || rd_a[$] !== 16'h0425) begin
      fails++; $display("FAIL rstmid_reads: got %0d last %h exp 38 0425", rd_cyc.size(), rd_a[$]);
    end
    tests++;
    if ({post_ready, post_rd, post_busy} !== 3'b100 || done_cyc !== -1) begin
      fails++; $display("FAIL rstmid_idle: got ready/rd/busy %b done %0d exp 100 -1",
                        {post_ready, post_rd, post_busy}, done_cyc);
    end
    run_tile(2, 16'h0900, 16'h0A00, 0, 0, -1);
    tests++;
    if (rdy0 !== 1'b1 || read_errs(2, 16'h0900, 16'h0A00) !== 0 || done_cyc !== 12) begin
      fails++; $display("FAIL rstmid_next: got ready %b errors %0d done %0d exp 1 0 12",
                        rdy0, read_errs(2, 16'h0900, 16'h0A00), done_cyc);
    end
  endtask

  task automatic test_back_to_back;
    int ks[3] = '{3, 0, 5};
    for (int t = 0; t < 3; t++) begin
      run_tile(ks[t], 16'h0C00, 16'h0D00, 0, 0, -1);
      tests++;
      if (rdy0 !== 1'b1 || done_cyc !== exp_done(ks[t])) begin
        fails++; $display("FAIL b2b_%0d: got ready %b done %0d exp 1 %0d", t, rdy0, done_cyc, exp_done(ks[t]));
      end
    end
  endtask

  task automatic test_random;
    int k, bad, rm;
    logic [ADDRW-1:0] ab, wb;
    for (int t = 0; t < 8; t++) begin
      k = $urandom_range(1, 20); bad = $urandom_range(0, 3); rm = $urandom_range(0, 2);
      ab = ADDRW'($urandom); wb = ADDRW'($urandom);
      run_tile(k, ab, wb, bad, rm, -1);
      tests++;
      if (read_errs(k, ab, wb) !== 0 || rdy0 !== 1'b1) begin
        fails++; $display("FAIL rand_reads_%0d: got %0d errors ready %b exp 0 1 (k=%0d)", t, read_errs(k, ab, wb), rdy0, k);
      end
      tests++;
      if (done_cyc !== exp_done(k) || or_cyc.size() != ROWS || viol_nr + viol_part != 0 || err_cyc !== -1) begin
        fails++; $display("FAIL rand_drain_%0d: got done %0d beats %0d viol %0d err %0d exp %0d 8 0 -1",
                          t, done_cyc, or_cyc.size(), viol_nr + viol_part, err_cyc, exp_done(k));
      end
    end
  endtask

  initial begin
    test_reset;
    test_issue;
    test_drain_k3;
    test_partial;
    test_kzero;
    test_wrap;
    test_reset_mid;
    test_back_to_back;
    test_random;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
